// File: rtl/prog_timer_if.sv
// prog_timer control/status bundle.
// Master drives control and settings; slave is the timer.
interface prog_timer_if #(
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 8
);
    logic                   enable_i;
    logic                   start_i;
    logic                   stop_i;
    logic                   mode_i;
    logic [WIDTH-1:0]       load_i;
    logic [PRESC_WIDTH-1:0] presc_i;
    logic                   irq_clr_i;
    logic [WIDTH-1:0]       count_o;
    logic                   busy_o;
    logic                   overflow_o;
    logic                   irq_o;

    modport master (
        output enable_i, start_i, stop_i, mode_i,
        output load_i, presc_i, irq_clr_i,
        input  count_o, busy_o, overflow_o, irq_o
    );

    modport slave (
        input  enable_i, start_i, stop_i, mode_i,
        input  load_i, presc_i, irq_clr_i,
        output count_o, busy_o, overflow_o, irq_o
    );
endinterface

// File: rtl/prog_timer.sv
// Programmable timer: prescaler, terminal count, one-shot/periodic, pause.
// Optional TIMER_STICKY_IRQ_EN turns irq_o into a sticky, clearable flag.
module prog_timer #(
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 8
) (
    input logic         clk_i,
    input logic         rst_i,
    prog_timer_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic [PRESC_WIDTH-1:0] psc_q, psc_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   mode_q, mode_d;
    logic                   ovf_q, ovf_d;

    // Next state: stop beats start beats counting; pause holds everything.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        psc_d    = psc_q;
        period_d = period_q;
        presc_d  = presc_q;
        mode_d   = mode_q;
        ovf_d    = 1'b0;
        if (bus.stop_i) begin
            state_d = IDLE;
            count_d = '0;
            psc_d   = '0;
        end else if (bus.start_i) begin
            state_d  = RUN;
            count_d  = '0;
            psc_d    = '0;
            period_d = bus.load_i;
            presc_d  = bus.presc_i;
            mode_d   = bus.mode_i;
        end else if (state_q == RUN && bus.enable_i) begin
            if (psc_q == presc_q) begin
                psc_d = '0;
                if (count_q == period_q) begin
                    count_d = '0;
                    ovf_d   = 1'b1;
                    if (!mode_q) begin
                        state_d = IDLE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                psc_d = psc_q + PRESC_WIDTH'(1);
            end
        end
    end

    // Register the FSM, counters, latched settings and overflow pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            psc_q    <= '0;
            period_q <= '0;
            presc_q  <= '0;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            psc_q    <= psc_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            mode_q   <= mode_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.count_o    = count_q;
    assign bus.busy_o     = (state_q == RUN);
    assign bus.overflow_o = ovf_q;

`ifdef TIMER_STICKY_IRQ_EN
    logic irq_q;

    // Sticky flag rises with overflow_o; a new overflow beats a clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= ovf_d | (irq_q & ~bus.irq_clr_i);
        end
    end

    assign bus.irq_o = irq_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = bus.irq_clr_i;
    assign bus.irq_o      = ovf_q;
`endif
endmodule

// File: tb/tb_prog_timer.sv
// Scoreboard bench for prog_timer: arithmetic reference model,
// stimulus pushes expectations, monitor pops and compares each cycle.
module tb_prog_timer;
    localparam int W  = 8;
    localparam int PW = 3;

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         ovf;
        logic         irq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prog_timer_if #(.WIDTH(W), .PRESC_WIDTH(PW)) bus ();

    prog_timer #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;

    // Reference model: n counts enabled cycles since start; outputs
    // follow from n by division against the latched period/prescale.
    bit      m_run = 1'b0;
    bit      m_mode = 1'b0;
    int      m_load = 0;
    int      m_presc = 0;
    longint  m_n = 0;
    bit      m_irq = 1'b0;

    task automatic drive(input bit r, input bit en, input bit st,
                         input bit sp, input bit md, input int ld,
                         input int ps, input bit clr);
        exp_t e;
        bit   ovf;
        longint per;
        @(negedge clk);
        rst           = r;
        bus.enable_i  = en;
        bus.start_i   = st;
        bus.stop_i    = sp;
        bus.mode_i    = md;
        bus.load_i    = W'(ld);
        bus.presc_i   = PW'(ps);
        bus.irq_clr_i = clr;
        ovf = 1'b0;
        if (r) begin
            m_run = 0; m_n = 0; m_load = 0; m_presc = 0; m_mode = 0;
            m_irq = 0;
        end else begin
            if (sp) begin
                m_run = 0; m_n = 0;
            end else if (st) begin
                m_run = 1; m_n = 0;
                m_load = ld; m_presc = ps; m_mode = md;
            end else if (m_run && en) begin
                m_n++;
                per = longint'(m_load + 1) * longint'(m_presc + 1);
                if (m_n % per == 0) begin
                    ovf = 1'b1;
                    if (!m_mode) begin
                        m_run = 0; m_n = 0;
                    end
                end
            end
`ifdef TIMER_STICKY_IRQ_EN
            m_irq = ovf | (m_irq & ~clr);
`else
            m_irq = ovf;
`endif
        end
        e.count = m_run ? W'((m_n / (m_presc + 1)) % (m_load + 1)) : '0;
        e.busy  = m_run;
        e.ovf   = ovf;
        e.irq   = m_irq;
        exp_q.push_back(e);
    endtask

    task automatic run(input int cycles, input bit en);
        for (int i = 0; i < cycles; i++)
            drive(0, en, 0, 0, $urandom_range(0, 1),
                  $urandom_range(0, 255), $urandom_range(0, 7), 0);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, got, want,
                     $time);
        end
    endtask

    // Monitor: one expectation per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("count", int'(bus.count_o), int'(e.count));
                chk("busy", int'(bus.busy_o), int'(e.busy));
                chk("overflow", int'(bus.overflow_o), int'(e.ovf));
                chk("irq", int'(bus.irq_o), int'(e.irq));
            end
        end
    end

    initial begin
        bus.enable_i = 0; bus.start_i = 0; bus.stop_i = 0;
        bus.mode_i = 0; bus.load_i = '0; bus.presc_i = '0;
        bus.irq_clr_i = 0;
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        // idle ignores enable
        run(3, 1);
        // periodic load=3 presc=0
        drive(0, 1, 1, 0, 1, 3, 0, 0);
        run(13, 1);
        // one-shot load=2 presc=1
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 2, 1, 0);
        run(9, 1);
        // pause at count 2 for 3 cycles
        drive(0, 1, 1, 0, 1, 5, 0, 0);
        run(2, 1);
        run(3, 0);
        run(10, 1);
        // start collides with terminal tick
        drive(0, 1, 1, 0, 1, 3, 0, 0);
        run(3, 1);
        drive(0, 1, 1, 0, 1, 6, 0, 0);
        run(8, 1);
        // stop collides with terminal tick
        drive(0, 1, 1, 0, 1, 3, 0, 0);
        run(3, 1);
        drive(0, 1, 0, 1, 1, 3, 0, 0);
        run(3, 1);
        // reset mid-count, no resume without start
        drive(0, 1, 1, 0, 1, 10, 0, 0);
        run(4, 1);
        drive(1, 1, 0, 0, 1, 10, 0, 0);
        run(4, 1);
        // irq clear, and clear coincident with overflow
        drive(0, 1, 1, 0, 1, 1, 0, 0);
        run(3, 1);
        drive(0, 1, 0, 0, 1, 1, 0, 1);
        drive(0, 1, 0, 0, 1, 1, 0, 1);
        run(2, 1);
        drive(0, 1, 0, 0, 1, 1, 0, 1);
        run(2, 1);
        // load=0 ticks every cycle
        drive(0, 1, 1, 0, 1, 0, 0, 0);
        run(4, 1);
        // maximum period one-shot
        drive(0, 1, 1, 0, 0, 255, 7, 0);
        run(2052, 1);
        // random phase
        for (int i = 0; i < 4000; i++) begin
            bit big = ($urandom_range(0, 15) == 0);
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < 85,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 1),
                  big ? $urandom_range(0, 255) : $urandom_range(0, 7),
                  big ? $urandom_range(0, 7) : $urandom_range(0, 2),
                  $urandom_range(0, 7) == 0);
        end
        run(3, 1);
        repeat (3) @(posedge clk);
        #2;
        chk("drain", exp_q.size(), 0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        if (!done) begin
            $display("FAIL timeout: got running want finished");
            $fatal(1, "timeout");
        end
    end
endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Programmable timer; parametrised successor of the single free-running timer.
- Adds a loadable terminal count, a clock prescaler, one-shot/periodic modes, pause without loss of count, explicit start/stop and a visible count value.
- Sits beside control FSMs and lab top-levels as a delay or timebase generator.
- Produces a one-cycle overflow_o pulse at each terminal count.

Parameters:
WIDTH, 32, width of main counter and terminal count
PRESC_WIDTH, 8, width of prescaler counter and prescaler setting

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
enable_i  input  1  1 = count, 0 = pause (counters hold)
start_i  input  1  latch settings, clear counters, enter RUN (also restarts while running)
stop_i  input  1  abort, return to IDLE, clear counters
mode_i  input  1  0 = one-shot, 1 = periodic; sampled on start
load_i  input  WIDTH  terminal count; sampled on start
presc_i  input  PRESC_WIDTH  prescale divisor minus 1; sampled on start
irq_clr_i  input  1  clear sticky interrupt (see Optional Feature)
count_o  output  WIDTH  current main count
busy_o  output  1  1 while in RUN
overflow_o  output  1  one-cycle pulse at terminal count
irq_o  output  1  interrupt (see Optional Feature)

Behaviour:
- Clock clk_i, single domain. Reset: rst_i is synchronous, active-high.
- Reset values: state IDLE, count_o=0, prescaler count=0, latched settings=0, busy_o=0, overflow_o=0, irq_o=0.
- Priority at a clock edge: rst_i > stop_i > start_i > normal counting.
- All outputs are registered; busy_o is 1 exactly when state = RUN.
- State IDLE:
  - counters hold at 0; enable_i is ignored.
  - start_i=1: latch period_r=load_i, presc_r=presc_i, mode_r=mode_i; clear count and prescaler; go to RUN.
- State RUN, enable_i=0: all counters and state hold (pause). This differs from the earlier timer, which cleared on disable.
- State RUN, enable_i=1, prescaler:
  - if prescaler count == presc_r: tick=1, prescaler count <= 0;
  - else prescaler count +1.
  - presc_r=0 gives a tick every cycle.
- On a tick, if count == period_r (terminal):
  - count <= 0;
  - overflow_o=1 for the following cycle only;
  - mode_r=0: go to IDLE;
  - mode_r=1: stay in RUN.
- On a tick, if not terminal: count <= count+1. count never exceeds period_r.
- Overflow period: (period_r+1)*(presc_r+1) cycles.
  - First overflow is visible (period_r+1)*(presc_r+1) edges after the edge that samples start_i.
  - Example: load=3, presc=0, start at edge 0 → count 1,2,3 after edges 1..3; after edge 4 count=0, overflow_o=1.
- load_i=0: every tick is terminal; count_o stays 0.
- Maximum period: load=all-ones with presc=all-ones is legal; there is no internal wrap beyond period_r.
- start_i in RUN: immediate restart with newly sampled settings.
  - If it coincides with a terminal tick, start wins and no overflow pulse is issued.
- stop_i in any state: go to IDLE, count=0, prescaler=0, no overflow pulse, even on a coincident terminal tick.
- Changes to load_i, presc_i or mode_i while running have no effect until the next start_i.
- rst_i mid-count: all state returns to reset values at that edge; a pending overflow is dropped.

Optional Feature:
Macro TIMER_STICKY_IRQ_EN.
- Defined:
  - irq_o is a sticky flag, set on any cycle where overflow_o is asserted.
  - Cleared at the edge that samples irq_clr_i=1; a simultaneous set wins over clear.
  - Reset clears it.
- Undefined:
  - irq_o equals overflow_o (one-cycle pulse, same timing).
  - irq_clr_i is ignored.
  - The port list is identical in both builds.

Test Plan:
- Reset, then load=3, presc=0, mode=1, start pulse → overflow_o pulses after edges 4, 8, 12; count_o sequence 1,2,3,0 repeats; busy_o stays 1.
- load=2, presc=1, mode=0, start → overflow_o after edge 6 only; busy_o=0 from edge 6; count_o=0 and stays 0.
- load=5, presc=0, mode=1, enable_i low for 3 cycles at count=2 → count holds at 2; overflow is delayed by exactly 3 cycles (edge 9 instead of 6).
- Two collisions:
  - start_i asserted on the terminal-tick edge → no overflow pulse; count restarts from 0 with the new load.
  - stop_i asserted on the terminal-tick edge → IDLE, no pulse.
- rst_i asserted at count=4 of load=10 → the next cycle shows count_o=0, busy_o=0, overflow_o=0, irq_o=0; start_i is required to resume.
- With TIMER_STICKY_IRQ_EN: after an overflow, irq_o stays 1 until irq_clr_i; irq_clr_i coincident with a new overflow leaves irq_o=1. Without the macro: irq_o mirrors overflow_o exactly.
